multicycle_fsm: RTL
===================

MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1: 1 = illegal opcode enters HALT; 0 = illegal opcode returns to FETCH.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port op  in  7  opcode, taken from the instruction register.
REQ-005 SHALL have port funct3  in  3  instruction bits 14:12.
REQ-006 SHALL have port funct7b5  in  1  instruction bit 30.
REQ-007 SHALL have port zero  in  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  in  1  unified memory has completed the current access.
REQ-009 SHALL have outputs pc_write, adr_src, mem_write, ir_write and reg_write, each out 1.
REQ-010 SHALL have outputs result_src, alu_src_a, alu_src_b and imm_src, each out 2.
REQ-011 SHALL have output alu_control  out  3, encoded as add 010, sub 110, and 000, or 001, slt 111.
REQ-012 SHALL have outputs state  out  4 (debug), halted  out  1, and instret  out  1 (one-cycle retire pulse).

Function
REQ-013 SHALL use state encoding FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
REQ-014 SHALL drive every output from the registered state plus op/funct/zero/mem_ready only: Moore for control, gated by mem_ready where stated; all unlisted controls are 0.
REQ-015 SHALL behave in FETCH as: adr_src=0, alu_src_a=00, alu_src_b=10, alu_control add, result_src=10, ir_write=mem_ready, pc_write=mem_ready; stay while mem_ready=0, otherwise go to DECODE.
REQ-016 SHALL behave in DECODE as: alu_src_a=01, alu_src_b=01, add; next state 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->HALT or FETCH per HALT_ON_ILLEGAL.
REQ-017 SHALL behave in MEMADR as: alu_src_a=10, alu_src_b=01, add; op[5]=0->MEMREAD, else MEMWRITE.
REQ-018 SHALL behave in MEMREAD as: adr_src=1, result_src=00; hold until mem_ready, then go to MEMWB.
REQ-019 SHALL behave in MEMWB as: result_src=01, reg_write=1, instret=1; then go to FETCH.
REQ-020 SHALL behave in MEMWRITE as: adr_src=1, mem_write=1 every cycle in state; hold until mem_ready, then FETCH with instret=1 in the mem_ready cycle.
REQ-021 SHALL behave in EXECR as: alu_src_a=10, alu_src_b=00, ALU op from funct (REQ-025); in EXECI as: alu_src_a=10, alu_src_b=01, ALU op from funct; both go to ALUWB.
REQ-022 SHALL behave in ALUWB as: result_src=00, reg_write=1, instret=1; then go to FETCH.
REQ-023 SHALL behave in BEQ as: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, instret=1; then go to FETCH.
REQ-024 SHALL behave in JAL as: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, reg_write=0, instret=0; then go to ALUWB, which writes PC+4 and pulses instret.
REQ-025 SHALL decode funct in EXECR/EXECI as: 000->sub only if funct7b5&op[5], else add; 010->slt; 110->or; 111->and; other funct3->HALT/FETCH per REQ-016, with reg_write suppressed.
REQ-026 SHALL set imm_src from op combinationally in all states: I-type/lw 00, sw 01, beq 10, jal 11, other 00.
REQ-027 SHALL keep HALT absorbing: halted=1, all enables 0, no exit except reset.
REQ-028 SHALL give minimum latencies, with mem_ready held at 1, of: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-029 SHALL, when reset=0, force state=FETCH and halted=0 immediately (asynchronously), independent of clk.
REQ-030 SHALL hold all write enables (pc_write, ir_write, reg_write, mem_write) and instret at 0 while reset=0, even in FETCH with mem_ready=1.
REQ-031 SHALL resume at the first rising clk edge after reset deasserts; a reset mid-instruction (e.g. in MEMWRITE) shall abandon the instruction without a mem_write pulse after assertion.

Verification
REQ-032 SHALL cover: mem_ready=1, op=0000011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instret pulses once.
REQ-033 SHALL cover: op=0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH.
REQ-034 SHALL cover: op=0110011, funct3=000, funct7b5=1 -> alu_control=110 in EXECR; the same with op=0010011 -> 010.
REQ-035 SHALL cover: op=1100011 with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; both return to FETCH.
REQ-036 SHALL cover: op=1111111 with HALT_ON_ILLEGAL=1 -> state=11, halted=1 held for 20 cycles; reset low -> state=0 with no clk edge.
REQ-037 SHALL cover: mem_ready=0 in FETCH for 5 cycles -> ir_write=0 and pc_write=0 throughout, with state staying at 0.

Source files
------------

// File: rtl/multicycle_fsm.sv
// Control FSM for a multicycle RISC-V style datapath with a unified memory.
// State is registered; control outputs are decoded from state plus op/funct/zero/mem_ready.
module multicycle_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       halted,
  output logic       instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t st;
  state_t nxt;
  state_t illegal_nxt;
  logic       funct_ok;
  logic [2:0] funct_alu;

  assign illegal_nxt = HALT_ON_ILLEGAL ? HALT : FETCH;

  // Subtract only for R-type (op[5]=1) with funct7b5; I-type 000 is always addi.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt = st;
    case (st)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = EXECR;
          7'b0010011:             nxt = EXECI;
          7'b1100011:             nxt = BEQ;
          7'b1101111:             nxt = JAL;
          default:                nxt = illegal_nxt;
        endcase
      end
      MEMADR:   nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR,
      EXECI:    nxt = funct_ok ? ALUWB : illegal_nxt;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      JAL:      nxt = ALUWB;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FETCH;
    else        st <= nxt;
  end

  always_comb begin
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    instret     = 1'b0;
    case (st)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instret    = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        instret   = mem_ready;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
      end
      ALUWB: begin
        reg_write = 1'b1;
        instret   = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
        instret     = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // The async reset must also silence enables, since FETCH itself raises them on mem_ready.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      instret   = 1'b0;
    end
  end

  assign state  = st;
  assign halted = (st == HALT);

endmodule
